// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control unit: single-cycle logic/arith ops, bit-serial shift-add
// multiply and bit-serial left shift, with a start/done handshake and registered flags.
module alu_sequencer #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       opCode,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_NOT = 3'b010, OP_AND = 3'b011,
    OP_OR  = 3'b100, OP_XOR = 3'b101, OP_MUL = 3'b110, OP_SHL = 3'b111
  } op_t;

  state_t             state, state_nxt;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;

  // Completion staging: captured on the finishing edge, published one edge later with done.
  logic               fin_q;
  logic [WIDTH-1:0]   st_res;
  logic               st_zero, st_neg, st_c, st_v, st_ill;

  logic [SW-1:0]      shamt;
  logic               iter_op, last_step, finish;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH-1:0]   shl_nxt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_ill;

  assign shamt     = b_q[SW-1:0];
  assign iter_op   = (op_q == OP_MUL && MUL_EN) || (op_q == OP_SHL && shamt != '0);
  assign last_step = (state == S_ITER) && (cnt_q == CW'(1));
  assign finish    = ((state == S_EXEC) && !iter_op) || last_step;
  assign busy      = (state != S_IDLE);

  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = {1'b0, a_q} - {1'b0, b_q};
  assign mul_nxt = b_q[0] ? acc_q + mcand_q : acc_q;
  assign shl_nxt = {acc_q[WIDTH-2:0], 1'b0};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = iter_op ? S_ITER : S_IDLE;
      S_ITER:  if (cnt_q == CW'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Final result/flags of whichever operation completes on this edge.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    if (state == S_ITER) begin
      if (op_q == OP_MUL) begin
        alu_res = mul_nxt[WIDTH-1:0];
        alu_v   = |mul_nxt[2*WIDTH-1:WIDTH];
      end else begin
        alu_res = shl_nxt;
        alu_c   = acc_q[WIDTH-1];
      end
    end else begin
      case (op_q)
        OP_ADD: begin
          alu_res = sum[WIDTH-1:0];
          alu_c   = sum[WIDTH];
          alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          alu_res = diff[WIDTH-1:0];
          alu_c   = diff[WIDTH];
          alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_NOT:  alu_res = ~a_q;
        OP_AND:  alu_res = a_q & b_q;
        OP_OR:   alu_res = a_q | b_q;
        OP_XOR:  alu_res = a_q ^ b_q;
        OP_MUL:  alu_ill = 1'b1;
        OP_SHL:  alu_res = a_q;
        default: alu_res = '0;
      endcase
    end
  end

  // NOTE: operand and datapath registers are cleared too, so reset leaves no stale state behind.
  always_ff @(posedge clock) begin
    if (clear) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      fin_q    <= 1'b0;
      st_res   <= '0;
      st_zero  <= 1'b0;
      st_neg   <= 1'b0;
      st_c     <= 1'b0;
      st_v     <= 1'b0;
      st_ill   <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        a_q  <= inputA;
        b_q  <= inputB;
        op_q <= op_t'(opCode);
      end

      if (state == S_EXEC) begin
        cnt_q   <= (op_q == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
        acc_q   <= (op_q == OP_MUL) ? '0 : {{WIDTH{1'b0}}, a_q};
        mcand_q <= {{WIDTH{1'b0}}, a_q};
      end

      if (state == S_ITER) begin
        cnt_q <= cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_q   <= mul_nxt;
          mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
        end else begin
          acc_q <= {{WIDTH{1'b0}}, shl_nxt};
        end
      end

      fin_q <= finish;
      if (finish) begin
        st_res  <= alu_res;
        st_zero <= !alu_ill && (alu_res == '0);
        st_neg  <= alu_res[WIDTH-1];
        st_c    <= alu_c;
        st_v    <= alu_v;
        st_ill  <= alu_ill;
      end

      done <= fin_q;
      if (fin_q) begin
        result   <= st_res;
        zero     <= st_zero;
        negative <= st_neg;
        carry    <= st_c;
        overflow <= st_v;
        illegal  <= st_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-level reference model compared every
// cycle, directed literal cases, randomized traffic, and a MUL_EN=0 instance.
module tb_alu_sequencer;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic         start = 1'b0;
  logic         start0 = 1'b0;
  logic [2:0]   opCode = '0;
  logic [W-1:0] inputA = '0;
  logic [W-1:0] inputB = '0;

  logic         busy, done, zero, negative, carry, overflow, illegal;
  logic [W-1:0] result;
  logic         busy0, done0, zero0, negative0, carry0, overflow0, illegal0;
  logic [W-1:0] result0;

  alu_sequencer #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clock(clock), .clear(clear), .start(start), .opCode(opCode),
    .inputA(inputA), .inputB(inputB), .busy(busy), .done(done), .result(result),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  alu_sequencer #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clock(clock), .clear(clear), .start(start0), .opCode(opCode),
    .inputA(inputA), .inputB(inputB), .busy(busy0), .done(done0), .result(result0),
    .zero(zero0), .negative(negative0), .carry(carry0), .overflow(overflow0), .illegal(illegal0)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic         c, v, z, n, ill;
    int           lat;
  } exp_t;

  // Spec-level result of one operation, computed with wide integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit mul_en);
    exp_t         e;
    longint       ua, ub, sa, sb, r, smax, smin, lim;
    logic [W-1:0] t;
    int           cnt;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lim  = longint'(1) << W;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.lat = 2; r = 0;
    case (op)
      3'd0: begin r = ua + ub; e.c = (r >= lim); e.v = (sa + sb > smax) || (sa + sb < smin); end
      3'd1: begin r = ua - ub; e.c = (ua < ub);  e.v = (sa - sb > smax) || (sa - sb < smin); end
      3'd2: begin t = ~a;    r = longint'(t); end
      3'd3: begin t = a & b; r = longint'(t); end
      3'd4: begin t = a | b; r = longint'(t); end
      3'd5: begin t = a ^ b; r = longint'(t); end
      3'd6: begin
        if (mul_en) begin r = ua * ub; e.v = ((r >> W) != 0); e.lat = W + 2; end
        else e.ill = 1'b1;
      end
      default: begin
        cnt = int'(ub % W);
        r = ua << cnt;
        e.c = (cnt != 0) && (((ua >> (W - cnt)) & 1) != 0);
        e.lat = (cnt == 0) ? 2 : cnt + 2;
      end
    endcase
    e.res = r[W-1:0];
    e.z   = !e.ill && (e.res == '0);
    e.n   = e.res[W-1];
    return e;
  endfunction

  // Transaction-level tracking of the main instance: accept edge, done edge, busy window.
  int   cyc = 0;
  int   busy_until = -1;
  int   done_edge = -1;
  int   accept_from = 0;
  bit   m_valid = 1'b0;
  bit   m_done = 1'b0;
  exp_t pend, cur;

  always @(posedge clock) begin
    cyc++;
    if (clear) begin
      m_valid = 1'b1;
      busy_until = -1;
      done_edge = -1;
      accept_from = 0;
      m_done = 1'b0;
      cur = '{res: '0, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0, ill: 1'b0, lat: 0};
    end else begin
      m_done = (cyc == done_edge);
      if (m_done) cur = pend;
      if (start && cyc >= accept_from) begin
        pend        = model(opCode, inputA, inputB, 1'b1);
        done_edge   = cyc + pend.lat;
        busy_until  = cyc + pend.lat - 2;
        accept_from = cyc + pend.lat;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("m_busy",     32'(busy),     32'(cyc <= busy_until));
      check("m_done",     32'(done),     32'(m_done));
      check("m_result",   32'(result),   32'(cur.res));
      check("m_zero",     32'(zero),     32'(cur.z));
      check("m_negative", 32'(negative), 32'(cur.n));
      check("m_carry",    32'(carry),    32'(cur.c));
      check("m_overflow", 32'(overflow), 32'(cur.v));
      check("m_illegal",  32'(illegal),  32'(cur.ill));
    end
  end

  // One start pulse on the main instance; returns latency and busy-cycle count.
  // poke > 0 re-asserts start for one cycle mid-operation.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke, output int lat, output int bcnt);
    @(posedge clock); #1;
    start = 1'b1; opCode = op; inputA = a; inputB = b;
    @(posedge clock); #1;
    start = 1'b0; inputA = W'($urandom); inputB = W'($urandom); opCode = 3'($urandom);
    lat = -1;
    bcnt = 0;
    @(negedge clock);
    if (busy) bcnt++;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clock);
      @(negedge clock);
      start = (k == poke);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 64 cycles for op %0d", op);
    end
  endtask

  task automatic do_op0(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(posedge clock); #1;
    start0 = 1'b1; opCode = op; inputA = a; inputB = b;
    @(posedge clock); #1;
    start0 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (done0) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done0_timeout: no done within 16 cycles for op %0d", op);
    end
  endtask

  initial begin
    int lat, bc;
    bit seen;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy",   32'(busy),    32'd0);
    check("reset_done",   32'(done),    32'd0);
    check("reset_result", 32'(result),  32'd0);
    check("reset_flags",  32'({zero, negative, carry, overflow, illegal}), 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;

    do_op(3'b000, 16'd805, 16'd302, 0, lat, bc);
    check("add_lat", 32'(lat), 32'd2);
    check("add_res", 32'(result), 32'h0453);
    check("add_cvz", 32'({carry, overflow, zero}), 32'd0);

    // SUB then back-to-back SUB with start held through done.
    @(posedge clock); #1;
    start = 1'b1; opCode = 3'b001; inputA = 16'd805; inputB = 16'd302;
    @(posedge clock); #1;
    @(posedge clock); #1;
    inputA = 16'd302; inputB = 16'd805;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("sub1_done",  32'(done),   32'd1);
    check("sub1_res",   32'(result), 32'h01F7);
    check("sub1_carry", 32'(carry),  32'd0);
    check("sub2_busy",  32'(busy),   32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("sub2_done",  32'(done),   32'd1);
    check("sub2_res",   32'(result), 32'hFE09);
    check("sub2_cnv",   32'({carry, negative, overflow}), 32'b110);

    do_op(3'b010, 16'h012E, 16'h0000, 0, lat, bc);
    check("not_res", 32'(result), 32'hFED1);
    check("not_neg", 32'(negative), 32'd1);

    do_op(3'b000, 16'h7FFF, 16'h0001, 0, lat, bc);
    check("addov_res", 32'(result), 32'h8000);
    check("addov_vn",  32'({overflow, negative}), 32'b11);

    do_op(3'b110, 16'd300, 16'd200, 0, lat, bc);
    check("mul1_lat",  32'(lat), 32'd18);
    check("mul1_busy", 32'(bc),  32'd17);
    check("mul1_res",  32'(result), 32'hEA60);
    check("mul1_ov",   32'(overflow), 32'd0);

    do_op(3'b110, 16'd300, 16'd300, 5, lat, bc);
    check("mul2_lat", 32'(lat), 32'd18);
    check("mul2_res", 32'(result), 32'h5F90);
    check("mul2_ov",  32'(overflow), 32'd1);

    do_op(3'b111, 16'h0001, 16'd15, 0, lat, bc);
    check("shl15_lat", 32'(lat), 32'd17);
    check("shl15_res", 32'(result), 32'h8000);
    check("shl15_c",   32'(carry), 32'd0);

    do_op(3'b111, 16'h8001, 16'd1, 0, lat, bc);
    check("shl1_res", 32'(result), 32'h0002);
    check("shl1_c",   32'(carry), 32'd1);

    do_op(3'b111, 16'h1234, 16'd16, 0, lat, bc);
    check("shl0_lat", 32'(lat), 32'd2);
    check("shl0_res", 32'(result), 32'h1234);
    check("shl0_c",   32'(carry), 32'd0);

    // Clear in the middle of a multiply.
    @(posedge clock); #1;
    start = 1'b1; opCode = 3'b110; inputA = 16'd300; inputB = 16'd200;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1 clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    check("clr_busy",   32'(busy),   32'd0);
    check("clr_result", 32'(result), 32'd0);
    check("clr_flags",  32'({done, zero, negative, carry, overflow, illegal}), 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check("clr_no_done", 32'(seen), 32'd0);

    do_op0(3'b110, 16'd300, 16'd200, lat);
    check("ill_lat",   32'(lat), 32'd2);
    check("ill_flag",  32'(illegal0), 32'd1);
    check("ill_res",   32'(result0), 32'd0);
    check("ill_flags", 32'({zero0, negative0, carry0, overflow0}), 32'd0);
    do_op0(3'b000, 16'd3, 16'd4, lat);
    check("ill_clr",     32'(illegal0), 32'd0);
    check("ill_add_res", 32'(result0), 32'd7);

    // Randomized traffic: starts while busy, back-to-back starts, occasional clears.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clock); #1;
      start  = ($urandom_range(2) == 0);
      clear  = ($urandom_range(299) == 0);
      opCode = 3'($urandom);
      inputA = W'($urandom);
      inputB = W'($urandom);
      case ($urandom_range(7))
        0: inputA = 16'h7FFF;
        1: inputA = 16'h8000;
        2: inputB = 16'hFFFF;
        3: inputB = inputA;
        default: ;
      endcase
    end
    @(posedge clock); #1;
    start = 1'b0;
    clear = 1'b0;
    repeat (40) @(posedge clock);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
